// File: rtl/riscv_pkg.sv
// Shared RV32 definitions: data width, major opcodes, the canonical NOP and
// the fetch-stage state encoding.
package riscv_pkg;

  localparam int XLEN = 32;

  localparam logic [6:0] OPC_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    FETCH_REQ  = 2'd0,
    FETCH_WAIT = 2'd1,
    FETCH_HOLD = 2'd2
  } fetch_state_e;

  // Forces word alignment while still consuming every bit of the input.
  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return addr & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding request, registered instruction
// output held until downstream consumes it, redirect/flush with response kill.
module if_stage
  import riscv_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            stall_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            valid_o,
  output logic [XLEN-1:0] instr_o,
  output logic [XLEN-1:0] pc_o,
  output logic [6:0]      opcode_o
);

  fetch_state_e    state;
  logic [XLEN-1:0] fetch_pc;
  // Set when the in-flight response belongs to a squashed fetch.
  logic            kill;

  assign imem_req_o  = rst_n && (state == FETCH_REQ);
  assign imem_addr_o = fetch_pc;
  assign opcode_o    = instr_o[6:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH_REQ;
      fetch_pc <= RESET_PC;
      kill     <= 1'b0;
      valid_o  <= 1'b0;
      instr_o  <= NOP_INSTR;
      pc_o     <= '0;
    end else if (redirect_i) begin
      fetch_pc <= word_align(redirect_pc_i);
      valid_o  <= 1'b0;
      case (state)
        FETCH_REQ: begin
          // A request granted this cycle still returns data; mark it dead.
          if (imem_gnt_i) begin
            state <= FETCH_WAIT;
            kill  <= 1'b1;
          end
        end
        FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            state <= FETCH_REQ;
            kill  <= 1'b0;
          end else begin
            kill  <= 1'b1;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end else begin
      case (state)
        FETCH_REQ: begin
          if (imem_gnt_i) state <= FETCH_WAIT;
        end
        FETCH_WAIT: begin
          if (imem_rvalid_i) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= FETCH_REQ;
            end else begin
              instr_o  <= imem_rdata_i;
              pc_o     <= fetch_pc;
              valid_o  <= 1'b1;
              fetch_pc <= fetch_pc + 32'd4;
              state    <= FETCH_HOLD;
            end
          end
        end
        FETCH_HOLD: begin
          if (!stall_i) begin
            valid_o <= 1'b0;
            state   <= FETCH_REQ;
          end
        end
        default: state <= FETCH_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: behavioural instruction memory, expected
// {pc, instr} queue checked on every presented instruction.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [6:0]  opcode_o;

  logic [63:0] exp_q[$];
  int          passed;
  int          total;
  int          rsp_delay;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .valid_o       (valid_o),
    .instr_o       (instr_o),
    .pc_o          (pc_o),
    .opcode_o      (opcode_o)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h0050_0093;
    if (a == 32'h4) return 32'h00A0_0113;
    return {a[26:2], 7'b0110011};
  endfunction

  // memory model: samples the handshake late in the cycle, answers after
  // rsp_delay cycles, forgets everything on reset
  initial begin : responder
    logic        hs;
    logic        in_rst;
    logic [31:0] hs_addr;
    logic [31:0] pend;
    int          cnt;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'hDEAD_BEEF;
    cnt  = 0;
    pend = '0;
    forever begin
      @(negedge clk);
      #4;
      hs      = imem_req_o && imem_gnt_i;
      hs_addr = imem_addr_o;
      in_rst  = !rst_n;
      @(posedge clk);
      #1;
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = 32'hDEAD_BEEF;
      if (in_rst) begin
        cnt = 0;
      end else begin
        if (hs) begin
          cnt  = rsp_delay;
          pend = hs_addr;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = mem_word(pend);
          end
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic expect_fetch(input logic [31:0] pc);
    exp_q.push_back({pc, mem_word(pc)});
  endtask

  // Waits (bounded) for the next presented instruction and scores it.
  task automatic wait_valid(input string tag, output int lat);
    logic [63:0] e;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!valid_o && lat < 30);
    if (!valid_o) begin
      check({tag, "_timeout"}, {31'd0, valid_o}, 32'd1);
    end else if (exp_q.size() == 0) begin
      check({tag, "_unexpected"}, pc_o, 32'hFFFF_FFFF);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_pc"}, pc_o, e[63:32]);
      check({tag, "_instr"}, instr_o, e[31:0]);
      check({tag, "_opcode"}, {25'd0, opcode_o}, {25'd0, e[6:0]});
    end
  endtask

  initial begin : main
    int          lat;
    int          n;
    logic [31:0] held_instr;
    passed        = 0;
    total         = 0;
    rsp_delay     = 1;
    rst_n         = 1'b0;
    imem_gnt_i    = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = '0;

    // reset values
    repeat (3) @(negedge clk);
    check("rst_req", {31'd0, imem_req_o}, 32'd0);
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_instr", instr_o, 32'h0000_0013);
    check("rst_pc", pc_o, 32'd0);
    check("rst_addr", imem_addr_o, 32'd0);

    // first two fetches back to back
    rst_n = 1'b1;
    #1;
    check("first_req", {31'd0, imem_req_o}, 32'd1);
    check("first_addr", imem_addr_o, 32'd0);
    expect_fetch(32'h0);
    expect_fetch(32'h4);
    wait_valid("fetch0", lat);
    check("fetch0_latency", lat, 32'd2);
    check("fetch0_op13", {25'd0, opcode_o}, 32'h13);
    wait_valid("fetch4", lat);
    check("fetch4_op13", {25'd0, opcode_o}, 32'h13);

    // hold under stall
    @(negedge clk);
    stall_i = 1'b1;
    expect_fetch(32'h8);
    wait_valid("fetch8", lat);
    held_instr = mem_word(32'h8);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, valid_o}, 32'd1);
      check("stall_pc", pc_o, 32'h8);
      check("stall_instr", instr_o, held_instr);
      check("stall_req", {31'd0, imem_req_o}, 32'd0);
    end

    // redirect beats stall; then grant withheld, request must stay put
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    @(negedge clk);
    redirect_i = 1'b0;
    stall_i    = 1'b0;
    imem_gnt_i = 1'b0;
    check("rs_valid", {31'd0, valid_o}, 32'd0);
    check("rs_req", {31'd0, imem_req_o}, 32'd1);
    check("rs_addr", imem_addr_o, 32'h200);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("nognt_req", {31'd0, imem_req_o}, 32'd1);
      check("nognt_addr", imem_addr_o, 32'h200);
    end
    imem_gnt_i = 1'b1;
    expect_fetch(32'h200);
    wait_valid("fetch200", lat);
    check("fetch200_latency", lat, 32'd2);

    // redirect in WAIT, stale response 3 cycles after grant
    rsp_delay = 3;
    @(negedge clk);
    check("pre_wait_addr", imem_addr_o, 32'h204);
    @(negedge clk);
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    @(negedge clk);
    redirect_i = 1'b0;
    check("kill_addr", imem_addr_o, 32'h100);
    check("kill_req", {31'd0, imem_req_o}, 32'd0);
    expect_fetch(32'h100);
    n = 0;
    while (!imem_req_o && n < 10) begin
      check("kill_no_valid", {31'd0, valid_o}, 32'd0);
      @(negedge clk);
      n++;
    end
    check("kill_next_req", {31'd0, imem_req_o}, 32'd1);
    check("kill_next_addr", imem_addr_o, 32'h100);
    wait_valid("fetch100", lat);

    // PC wrap; low redirect bits must be ignored
    rsp_delay     = 1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFD;
    @(negedge clk);
    redirect_i = 1'b0;
    check("wrap_addr", imem_addr_o, 32'hFFFF_FFFC);
    expect_fetch(32'hFFFF_FFFC);
    wait_valid("fetch_top", lat);
    @(negedge clk);
    check("wrap_req", {31'd0, imem_req_o}, 32'd1);
    check("wrap_next_addr", imem_addr_o, 32'h0);

    // one-cycle reset while a response is pending
    rsp_delay = 3;
    @(negedge clk);
    check("wait_before_rst", {31'd0, imem_req_o}, 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst2_req", {31'd0, imem_req_o}, 32'd1);
    check("rst2_addr", imem_addr_o, 32'h0);
    check("rst2_valid", {31'd0, valid_o}, 32'd0);
    check("rst2_instr", instr_o, 32'h0000_0013);
    expect_fetch(32'h0);
    wait_valid("fetch_after_rst", lat);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
